astable_555: RTL and testbench

Emulates a 555 timer wired as an astable multivibrator by counting clock cycles. It produces a free-running rectangular wave with parameterised high and low phase lengths, and a run-time selectable alternate period. It is the source-side counterpart of the monostable oneshot emulation: it generates the periodic trigger and tone waveforms that oneshots and sound logic consume. A per-period start strobe is provided for downstream edge-free triggering.

---
 rtl/astable_555.sv | 113 +++++++++++
 tb/tb_astable_555.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/astable_555.sv
// Cycle-counting emulation of a 555 timer in astable mode: a free-running
// rectangular wave with a primary and an alternate set of phase lengths.
module astable_555 #(
  parameter int HIGH_COUNTS     = 600,
  parameter int LOW_COUNTS      = 400,
  parameter int ALT_HIGH_COUNTS = 300,
  parameter int ALT_LOW_COUNTS  = 200,
  localparam int MAX_PRI        = (HIGH_COUNTS > LOW_COUNTS) ? HIGH_COUNTS : LOW_COUNTS,
  localparam int MAX_ALT        = (ALT_HIGH_COUNTS > ALT_LOW_COUNTS) ? ALT_HIGH_COUNTS : ALT_LOW_COUNTS,
  localparam int MAX_COUNTS     = (MAX_PRI > MAX_ALT) ? MAX_PRI : MAX_ALT,
  parameter int BIT_WIDTH       = ($clog2(MAX_COUNTS) < 1) ? 1 : $clog2(MAX_COUNTS)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ENABLE,
  input  logic       ALT_SEL,
  output logic       OUT,
  output logic       CYCLE_START,
  output logic [1:0] STATE_DBG
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Terminal counts are stored as length-1 so the compare needs no adder.
  localparam logic [BIT_WIDTH-1:0] HI_TERM     = BIT_WIDTH'(HIGH_COUNTS - 1);
  localparam logic [BIT_WIDTH-1:0] LO_TERM     = BIT_WIDTH'(LOW_COUNTS - 1);
  localparam logic [BIT_WIDTH-1:0] ALT_HI_TERM = BIT_WIDTH'(ALT_HIGH_COUNTS - 1);
  localparam logic [BIT_WIDTH-1:0] ALT_LO_TERM = BIT_WIDTH'(ALT_LOW_COUNTS - 1);

  state_t               state;
  logic [BIT_WIDTH-1:0] counter;
  logic                 sel_q;
  logic [BIT_WIDTH-1:0] hi_term;
  logic [BIT_WIDTH-1:0] lo_term;

  assign hi_term   = sel_q ? ALT_HI_TERM : HI_TERM;
  assign lo_term   = sel_q ? ALT_LO_TERM : LO_TERM;
  assign STATE_DBG = state;

  // OUT and CYCLE_START are registered alongside the next state, so they are
  // exactly (state == HIGH) and (state == HIGH && counter == 0).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      counter     <= '0;
      sel_q       <= 1'b0;
      OUT         <= 1'b0;
      CYCLE_START <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          counter <= '0;
          if (ENABLE) begin
            state       <= HIGH;
            sel_q       <= ALT_SEL;
            OUT         <= 1'b1;
            CYCLE_START <= 1'b1;
          end else begin
            OUT         <= 1'b0;
            CYCLE_START <= 1'b0;
          end
        end
        HIGH: begin
          if (!ENABLE) begin
            state       <= IDLE;
            counter     <= '0;
            OUT         <= 1'b0;
            CYCLE_START <= 1'b0;
          end else if (counter == hi_term) begin
            state       <= LOW;
            counter     <= '0;
            OUT         <= 1'b0;
            CYCLE_START <= 1'b0;
          end else begin
            counter     <= counter + 1'b1;
            OUT         <= 1'b1;
            CYCLE_START <= 1'b0;
          end
        end
        LOW: begin
          // Stop takes priority over the terminal count, so no strobe leaks out.
          if (!ENABLE) begin
            state       <= IDLE;
            counter     <= '0;
            OUT         <= 1'b0;
            CYCLE_START <= 1'b0;
          end else if (counter == lo_term) begin
            state       <= HIGH;
            counter     <= '0;
            sel_q       <= ALT_SEL;
            OUT         <= 1'b1;
            CYCLE_START <= 1'b1;
          end else begin
            counter     <= counter + 1'b1;
            OUT         <= 1'b0;
            CYCLE_START <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          counter     <= '0;
          OUT         <= 1'b0;
          CYCLE_START <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_astable_555.sv
// Directed bench for astable_555: waveform segments with hand-derived
// expected OUT/CYCLE_START, plus reset and length-1 phase sequences.
module tb_astable_555;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       alt;
  logic       en2;
  logic       out;
  logic       cs;
  logic [1:0] st;
  logic       out2;
  logic       cs2;
  logic [1:0] st2;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic  en;
    logic  alt;
    int    n;
    logic  out;
    logic  cs_first;
    string name;
  } seg_t;

  seg_t segs[$];

  always #5 clk = ~clk;

  astable_555 dut (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en), .ALT_SEL(alt),
    .OUT(out), .CYCLE_START(cs), .STATE_DBG(st)
  );

  astable_555 #(.HIGH_COUNTS(1), .LOW_COUNTS(1)) dut_fast (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en2), .ALT_SEL(alt),
    .OUT(out2), .CYCLE_START(cs2), .STATE_DBG(st2)
  );

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic e, input logic a, input int n,
                              input logic o, input logic c, input string name);
    segs.push_back('{en: e, alt: a, n: n, out: o, cs_first: c, name: name});
  endfunction

  // Drive one segment's inputs and check {OUT, CYCLE_START} after each edge.
  task automatic run_seg(input seg_t s);
    en  = s.en;
    alt = s.alt;
    for (int i = 0; i < s.n; i++) exp_q.push_back({s.out, s.cs_first && (i == 0)});
    for (int i = 0; i < s.n; i++) begin
      @(posedge clk); #1;
      check(s.name, {out, cs}, exp_q.pop_front());
    end
  endtask

  task automatic seg(input logic e, input logic a, input int n,
                     input logic o, input logic c, input string name);
    seg_t s;
    s = '{en: e, alt: a, n: n, out: o, cs_first: c, name: name};
    run_seg(s);
  endtask

  // Assert reset between edges, check outputs drop at once, release with ENABLE=1.
  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    #1 check(name, {out, cs}, 2'b00);
    check({name, "_state"}, st, 2'b00);
    @(posedge clk); #1;
    check({name, "_hold"}, {out, cs}, 2'b00);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    alt   = 1'b0;
    en2   = 1'b0;
    #1;
    check("reset_outputs", {out, cs}, 2'b00);
    check("reset_state", st, 2'b00);
    check("reset_fast_outputs", {out2, cs2}, 2'b00);
    #20 rst_n = 1'b1;

    add(1'b0, 1'b0, 2000, 1'b0, 1'b0, "idle");
    for (int p = 0; p < 5; p++) begin
      add(1'b1, 1'b0, 600, 1'b1, 1'b1, "primary_high");
      add(1'b1, 1'b0, 400, 1'b0, 1'b0, "primary_low");
    end
    // ALT_SEL rises mid-HIGH; it is sampled at the next HIGH entry only.
    add(1'b1, 1'b0, 300, 1'b1, 1'b1, "alt_p1_high_a");
    add(1'b1, 1'b1, 300, 1'b1, 1'b0, "alt_p1_high_b");
    add(1'b1, 1'b1, 400, 1'b0, 1'b0, "alt_p1_low");
    add(1'b1, 1'b1, 300, 1'b1, 1'b1, "alt_p2_high");
    add(1'b1, 1'b1, 100, 1'b0, 1'b0, "alt_p2_low_a");
    add(1'b1, 1'b0, 100, 1'b0, 1'b0, "alt_p2_low_b");
    add(1'b1, 1'b0, 600, 1'b1, 1'b1, "alt_p3_high");
    add(1'b1, 1'b0, 400, 1'b0, 1'b0, "alt_p3_low");
    // Stop at high count 250, then restart with a full phase.
    add(1'b1, 1'b0, 250, 1'b1, 1'b1, "stop_high");
    add(1'b0, 1'b0, 5,   1'b0, 1'b0, "stopped");
    add(1'b1, 1'b0, 600, 1'b1, 1'b1, "restart_high");
    add(1'b1, 1'b0, 400, 1'b0, 1'b0, "restart_low");
    // The first stopped edge coincides with the LOW terminal count.
    add(1'b0, 1'b0, 3,   1'b0, 1'b0, "stop_at_terminal");

    foreach (segs[k]) run_seg(segs[k]);

    seg(1'b1, 1'b0, 300, 1'b1, 1'b1, "pre_rst_high");
    async_reset("async_rst_high");
    seg(1'b1, 1'b0, 600, 1'b1, 1'b1, "post_rst1_high");
    seg(1'b1, 1'b0, 100, 1'b0, 1'b0, "pre_rst_low");
    async_reset("async_rst_low");
    seg(1'b1, 1'b0, 600, 1'b1, 1'b1, "post_rst2_high");
    seg(1'b1, 1'b0, 400, 1'b0, 1'b0, "post_rst2_low");
    seg(1'b0, 1'b0, 2,   1'b0, 1'b0, "final_stop");

    check("fast_idle_outputs", {out2, cs2}, 2'b00);
    check("fast_idle_state", st2, 2'b00);
    en2 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic e;
      e = (i % 2 == 0);
      @(posedge clk); #1;
      check("fast_toggle", {out2, cs2}, {e, e});
    end
    en2 = 1'b0;
    @(posedge clk); #1;
    check("fast_stop", {out2, cs2}, 2'b00);
    check("fast_stop_state", st2, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
